// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: the mode-select encodings.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: a 4:1 mode mux feeding a flop
// that clears asynchronously on reset.
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] s,
    input  logic       shl_in,
    input  logic       shr_in,
    input  logic       par_in,
    output logic       q
);

    logic d;

    // Nested ternaries let an unknown mode select propagate X into the flop.
    assign d = (s == MODE_LOAD) ? par_in :
               (s == MODE_SHR)  ? shr_in :
               (s == MODE_SHL)  ? shl_in : q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register (hold / shift left / shift right / load),
// built as a chain of usr_bit_cell instances.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    output logic [WIDTH-1:0] O,
    input  logic [WIDTH-1:0] I,
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       s,
    input  logic             SINR,
    input  logic             SINL
);

    logic [WIDTH-1:0] q_bits;
    logic [WIDTH-1:0] shl_src;
    logic [WIDTH-1:0] shr_src;

    // Bit 0 takes SINL on a left shift; bit WIDTH-1 takes SINR on a right shift.
    assign shl_src = {q_bits[WIDTH-2:0], SINL};
    assign shr_src = {SINR, q_bits[WIDTH-1:1]};

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            usr_bit_cell u_cell (
                .clk    (clk),
                .reset  (reset),
                .s      (s),
                .shl_in (shl_src[i]),
                .shr_in (shr_src[i]),
                .par_in (I[i]),
                .q      (q_bits[i])
            );
        end
    endgenerate

    assign O = q_bits;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register with a per-cycle
// arithmetic reference model and hand-computed literal checkpoints.
module tb_universal_shift_register;
    import usr_pkg::*;

    localparam int W = 4;

    logic [W-1:0] O;
    logic [W-1:0] I;
    logic         clk;
    logic         reset;
    logic [1:0]   s;
    logic         SINR;
    logic         SINL;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] model   = '0;
    bit           cmp_en  = 1'b0;

    universal_shift_register #(.WIDTH(W)) dut (
        .O     (O),
        .I     (I),
        .clk   (clk),
        .reset (reset),
        .s     (s),
        .SINR  (SINR),
        .SINL  (SINL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            n_tests++;
            if (O !== model) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t O=%b expected=%b", $time, O, model);
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] exp);
        n_tests++;
        if (O !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t O=%b expected=%b", name, $time, O, exp);
        end
    endtask

    // Apply one mode for one clock edge; the model follows the register rules arithmetically.
    task automatic step(input logic [1:0] mode, input logic sr, input logic sl,
                        input logic [W-1:0] din);
        s    = mode;
        SINR = sr;
        SINL = sl;
        I    = din;
        @(posedge clk);
        if (!reset) begin
            model = '0;
        end else begin
            case (mode)
                MODE_SHL:  model = W'((int'(model) * 2 + int'(sl)) % (1 << W));
                MODE_SHR:  model = W'(int'(model) / 2 + int'(sr) * (1 << (W - 1)));
                MODE_LOAD: model = din;
                default:   model = model;
            endcase
        end
        #1;
    endtask

    initial begin
        reset = 1'b0;
        s     = MODE_HOLD;
        SINR  = 1'b0;
        SINL  = 1'b0;
        I     = 4'b1010;
        model = '0;
        #1;
        chk("reset_initial", 4'b0000);
        cmp_en = 1'b1;

        // Reset held low: every mode is ignored.
        for (int k = 0; k < 4; k++) begin
            step(2'(k), 1'b1, 1'b1, 4'b1010);
            chk("reset_hold", 4'b0000);
        end

        reset = 1'b1;
        step(MODE_SHL, 1'b0, 1'b1, 4'b0000); chk("shl_1", 4'b0001);
        step(MODE_SHL, 1'b0, 1'b1, 4'b0000); chk("shl_2", 4'b0011);
        step(MODE_SHL, 1'b0, 1'b1, 4'b0000); chk("shl_3", 4'b0111);
        step(MODE_SHL, 1'b0, 1'b1, 4'b0000); chk("shl_4", 4'b1111);

        step(MODE_SHR, 1'b0, 1'b1, 4'b0000); chk("shr_1", 4'b0111);
        step(MODE_SHR, 1'b0, 1'b1, 4'b0000); chk("shr_2", 4'b0011);
        step(MODE_SHR, 1'b0, 1'b1, 4'b0000); chk("shr_3", 4'b0001);
        step(MODE_SHR, 1'b0, 1'b1, 4'b0000); chk("shr_4", 4'b0000);

        step(MODE_LOAD, 1'b0, 1'b0, 4'b1111); chk("load", 4'b1111);
        for (int k = 0; k < 5; k++) begin
            step(MODE_HOLD, 1'b1, 1'b0, 4'b0000);
            chk("hold", 4'b1111);
        end

        // Input glitches between edges must not be captured.
        #2 s = MODE_LOAD; I = 4'b0101;
        #2 s = MODE_SHR;
        step(MODE_HOLD, 1'b0, 1'b0, 4'b0000); chk("between_edges", 4'b1111);

        // Asynchronous reset in the middle of a left-shift run.
        step(MODE_LOAD, 1'b0, 1'b0, 4'b0000); chk("clear_load", 4'b0000);
        step(MODE_SHL, 1'b0, 1'b1, 4'b0000);
        step(MODE_SHL, 1'b0, 1'b1, 4'b0000);
        step(MODE_SHL, 1'b0, 1'b1, 4'b0000); chk("pre_async", 4'b0111);
        #2 reset = 1'b0;
        #1 chk("async_clear", 4'b0000);
        model = '0;
        #1 reset = 1'b1;
        step(MODE_SHL, 1'b0, 1'b1, 4'b0000); chk("restart_1", 4'b0001);
        step(MODE_SHL, 1'b0, 1'b1, 4'b0000); chk("restart_2", 4'b0011);

        // Mixed modes.
        step(MODE_LOAD, 1'b0, 1'b0, 4'b1001); chk("mix_load", 4'b1001);
        step(MODE_SHR,  1'b1, 1'b0, 4'b0000); chk("mix_shr",  4'b1100);
        step(MODE_SHL,  1'b1, 1'b0, 4'b0000); chk("mix_shl",  4'b1000);

        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the register width in bits (legal values are 2 or greater).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port O, output, WIDTH bits: registered parallel output, where O[WIDTH-1] is the MSB.
REQ-005 The module SHALL have port I, input, WIDTH bits: parallel load data.
REQ-006 The module SHALL have port s, input, 2 bits: mode select.
REQ-007 The module SHALL have port SINR, input, 1 bit: serial input entering the MSB on a right shift.
REQ-008 The module SHALL have port SINL, input, 1 bit: serial input entering the LSB on a left shift.
REQ-009 The positional port order SHALL be O, I, clk, reset, s, SINR, SINL.

Function
REQ-010 On each rising clk edge with reset high, s=2'b00 (HOLD) SHALL leave O unchanged.
REQ-011 On each rising clk edge with reset high, s=2'b01 (SHIFT LEFT) SHALL make O become {O[WIDTH-2:0], SINL}.
REQ-012 On each rising clk edge with reset high, s=2'b10 (SHIFT RIGHT) SHALL make O become {SINR, O[WIDTH-1:1]}.
REQ-013 On each rising clk edge with reset high, s=2'b11 (LOAD) SHALL make O become I.
REQ-014 Latency SHALL be one cycle: the new O is visible after the active edge; O SHALL NOT depend combinationally on I, s, SINR or SINL.
REQ-015 s, SINR, SINL and I SHALL be sampled only at the rising clk edge; changes between edges SHALL have no effect.
REQ-016 If s, SINR, SINL or I carry X/Z at an active edge, the affected bits SHALL become X in simulation; no X-suppression logic SHALL be added.
REQ-017 A shift SHALL discard the bit shifted out (O[WIDTH-1] on a left shift, O[0] on a right shift); no carry-out SHALL be provided.
REQ-018 The design SHALL have no enable input; HOLD is the only way to retain state.

Reset
REQ-019 While reset=0, O SHALL be forced to all zeros immediately, independent of clk.
REQ-020 While reset is held low, clk edges SHALL have no effect.
REQ-021 After reset deasserts, the first rising clk edge SHALL perform the operation selected by s.
REQ-022 Reset asserted in the middle of a shift sequence SHALL clear O, and that sequence SHALL NOT resume.

Structure
REQ-023 The mode encodings MODE_HOLD=2'b00, MODE_SHL=2'b01, MODE_SHR=2'b10 and MODE_LOAD=2'b11 SHALL be defined in a shared package, usr_pkg, and used by both the RTL and the bench.
REQ-024 Each bit SHALL be built from one sub-module, usr_bit_cell, containing a 4:1 mux (hold, left neighbour, right neighbour, parallel in) feeding a resettable flop; the cells SHALL be instantiated WIDTH times via generate.
REQ-025 The boundary neighbours SHALL be SINL for bit 0 on a left shift and SINR for bit WIDTH-1 on a right shift.

Verification
REQ-026 The bench SHALL cover reset: reset=0 with any s and I=4'b1010, with clk toggling -> O=4'b0000 throughout.
REQ-027 The bench SHALL cover left shift: release reset with O=0, s=01, SINL=1, four edges -> O = 0001, 0011, 0111, 1111.
REQ-028 The bench SHALL cover right shift: from O=1111, s=10, SINR=0, four edges -> O = 0111, 0011, 0001, 0000.
REQ-029 The bench SHALL cover load then hold: s=11, I=1111, one edge -> O=1111; then s=00, five edges with I changed to 0000 -> O stays 1111.
REQ-030 The bench SHALL cover asynchronous reset mid-operation: s=01 shifting with O=0111, reset pulsed low between edges -> O=0000 before the next edge, and shifting restarts from 0000 once reset is high.
REQ-031 The bench SHALL cover mixed modes: O=1001, s=10 with SINR=1 -> 1100; then s=01 with SINL=0 -> 1000.
